// File: rtl/matrix_result_serializer_pkg.sv
// Shared constants, FSM state type and flat-matrix addressing helper for the
// inverse-engine result serializer.
package matrix_pkg;

  localparam int unsigned MAT_N = 5;
  localparam int unsigned MAT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } ser_state_t;

  // LSB position of element (r,c) inside a flattened MAT_N x MAT_N matrix.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c);
    return (r * MAT_N + c) * MAT_W;
  endfunction

endpackage

// File: rtl/matrix_result_serializer_if.sv
// Word-stream interface of the serializer.
//   out_data  : current element (or row-sum word)
//   out_valid : data/row/col/last are valid
//   out_ready : downstream accepts the current word
//   out_row   : row index of out_data
//   out_col   : column index of out_data
//   out_last  : final word of the frame
interface matrix_result_serializer_if
  import matrix_pkg::*;
#(
  parameter int unsigned W     = MAT_W,
  parameter int unsigned IDX_W = 3
);

  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic             out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_result_serializer_index_counter.sv
// Row-major row/col counter for the serializer.
//   clk, reset    : clock, async active-low reset
//   clear_i       : restart at (0,0)
//   advance_i     : step to the next position, wrapping col at COLS and row at ROWS
//   row_o, col_o  : current position (registered)
//   last_o        : current position is the final one of the frame (registered)
module matrix_index_counter #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(COLS - 1);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             last_q, last_d;

  // Next position; last is derived from the next position so it stays registered.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
    last_d = (row_d == ROW_MAX) && (col_d == COL_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= last_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = last_q;

endmodule

// File: rtl/matrix_result_serializer.sv
// Snapshots an N x N matrix on start and streams it out row-major, one word
// per accepted valid/ready transfer.
//   clk, reset : clock, async active-low reset
//   start      : capture mat_in and begin a frame (ignored while a frame is active)
//   mat_in     : flattened matrix, element (r,c) at bits [(r*N+c)*W +: W]
//   out_if     : word stream (master side)
//   busy       : frame in progress
//   done       : one-cycle pulse after the final transfer
// Optional: MATRIX_SER_ROW_SUM_EN appends a wrapping row-sum word (col = N)
// after every row; out_last then marks the last row's sum word.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int unsigned N     = MAT_N,
  parameter int unsigned W     = MAT_W,
  parameter int unsigned IDX_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N*N*W-1:0]          mat_in,
  matrix_result_serializer_if.master out_if,
  output logic                      busy,
  output logic                      done
);

`ifdef MATRIX_SER_ROW_SUM_EN
  localparam int unsigned COLS = N + 1;
`else
  localparam int unsigned COLS = N;
`endif

  ser_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             capture_c, clear_c, advance_c;
  logic [N*N*W-1:0] buf_q;
  logic [IDX_W-1:0] row_c, col_c;
  logic             last_c;
  logic [W-1:0]     elem_c [N][N];
  logic [W-1:0]     data_c;

  matrix_index_counter #(
    .ROWS  (N),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_index (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear_c),
    .advance_i (advance_c),
    .row_o     (row_c),
    .col_o     (col_c),
    .last_o    (last_c)
  );

  // Snapshot buffer; only written on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
    end else if (capture_c) begin
      buf_q <= mat_in;
    end
  end

  // Unpack the buffer into an element array.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        elem_c[r][c] = buf_q[(r*N + c)*W +: W];
      end
    end
  end

  // Index mux from the registered buffer (plus row-sum word when enabled).
`ifdef MATRIX_SER_ROW_SUM_EN
  logic [W-1:0] sum_c;
`endif
  always_comb begin
    data_c = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (row_c == IDX_W'(r) && col_c == IDX_W'(c)) data_c = elem_c[r][c];
      end
    end
`ifdef MATRIX_SER_ROW_SUM_EN
    sum_c = '0;
    for (int r = 0; r < N; r++) begin
      if (row_c == IDX_W'(r)) begin
        for (int c = 0; c < N; c++) sum_c = sum_c + elem_c[r][c];
      end
    end
    if (col_c == IDX_W'(N)) data_c = sum_c;
`endif
  end

  // Frame control: next state, registered-output next values, counter strobes.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    capture_c = 1'b0;
    clear_c   = 1'b0;
    advance_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          clear_c   = 1'b1;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && out_if.out_ready) begin
          advance_c = 1'b1;
          if (last_c) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_if.out_data  = data_c;
  assign out_if.out_valid = valid_q;
  assign out_if.out_row   = row_c;
  assign out_if.out_col   = col_c;
  // Counter wraps to (0,0) on the final transfer, so last is only high mid-frame.
  assign out_if.out_last  = last_c;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer: stimulus pushes expected
// words, a negedge monitor pops and compares on every accepted transfer.
module tb_matrix_result_serializer;
  import matrix_pkg::*;

  localparam int unsigned N     = MAT_N;
  localparam int unsigned W     = MAT_W;
  localparam int unsigned IDX_W = 3;
`ifdef MATRIX_SER_ROW_SUM_EN
  localparam int unsigned COLS  = N + 1;
`else
  localparam int unsigned COLS  = N;
`endif
  localparam int unsigned FRAME = N * COLS;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [N*N*W-1:0] mat_in = '0;
  logic             busy, done;

  matrix_result_serializer_if #(.W(W), .IDX_W(IDX_W)) out_if ();

  matrix_result_serializer #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mat_in (mat_in),
    .out_if (out_if),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  word_t sb[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cycle = 0;
  int    n_xfer = 0;
  int    n_done = 0;
  int    last_xfer_cyc = -100;
  int    done_cyc = -100;
  logic  bp_mode = 1'b0;
  logic [3:0] pat = 4'b1001;  // ready pattern 1,0,0,1 (bit 0 first)
  int    ph = 0;
  word_t held;
  logic  holding = 1'b0;
  word_t exp_w;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Ready driver: constant 1 or the 1,0,0,1 backpressure pattern.
  initial out_if.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_if.out_ready = pat[ph];
      ph = (ph + 1) % 4;
    end else begin
      out_if.out_ready = 1'b1;
      ph = 0;
    end
  end

  // Monitor: compares accepted words, stability under backpressure, done pulse.
  always @(negedge clk) begin
    if (holding && out_if.out_valid) begin
      check("hold_data", out_if.out_data, held.data);
      check("hold_rowcol", {out_if.out_row, out_if.out_col, out_if.out_last},
            {held.row, held.col, held.last});
    end
    holding = 1'b0;
    if (out_if.out_valid && out_if.out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_word: got %0h, expected no word", out_if.out_data);
      end else begin
        exp_w = sb.pop_front();
        check("word_data", out_if.out_data, exp_w.data);
        check("word_row", out_if.out_row, exp_w.row);
        check("word_col", out_if.out_col, exp_w.col);
        check("word_last", out_if.out_last, exp_w.last);
      end
      n_xfer++;
      last_xfer_cyc = cycle;
    end else if (out_if.out_valid) begin
      holding = 1'b1;
      held    = '{out_if.out_data, out_if.out_row, out_if.out_col, out_if.out_last};
    end
    if (done) begin
      n_done++;
      done_cyc = cycle;
      check("done_busy_low", busy, 1'b0);
      check("done_latency", 64'(cycle - last_xfer_cyc), 64'd1);
    end
  end

  function automatic logic [N*N*W-1:0] pattern_mat();
    logic [N*N*W-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[elem_lsb(r, c) +: W] = W'(32'h100 * r + c);
    return m;
  endfunction

  task automatic push_frame(input logic [N*N*W-1:0] m);
    word_t        w;
    logic [W-1:0] s;
    for (int r = 0; r < N; r++) begin
      s = '0;
      for (int c = 0; c < N; c++) begin
        w.data = m[elem_lsb(r, c) +: W];
        s      = s + w.data;
        w.row  = IDX_W'(r);
        w.col  = IDX_W'(c);
        w.last = (COLS == N) && (r == N - 1) && (c == N - 1);
        sb.push_back(w);
      end
      if (COLS > N) begin
        w.data = s;
        w.col  = IDX_W'(N);
        w.last = (r == N - 1);
        sb.push_back(w);
      end
    end
  endtask

  // Called at posedge+1; start is sampled on the next edge.
  task automatic pulse_start(input logic [N*N*W-1:0] m, output int c0);
    mat_in = m;
    start  = 1'b1;
    c0     = cycle;
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_rise", out_if.out_valid, 1'b1);
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", 64'(n_done >= target), 64'd1);
  endtask

  task automatic wait_xfer(input int target);
    int k;
    k = 0;
    while (n_xfer < target && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("xfer_reached", 64'(n_xfer >= target), 64'd1);
  endtask

  task automatic idle_cycles(input int n, input int done_ref);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_valid", out_if.out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    check("no_extra_done", 64'(n_done), 64'(done_ref));
  endtask

  initial begin
    int c0, x0, d0;
    logic [N*N*W-1:0] m;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", out_if.out_data, '0);
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_rowcol", {out_if.out_row, out_if.out_col, out_if.out_last}, '0);
    check("rst_busy_done", {busy, done}, 2'b00);
    reset = 1'b1;
    idle_cycles(10, 0);

    // Basic frame, ready held high: N*COLS consecutive words.
    m = pattern_mat();
    push_frame(m);
    x0 = n_xfer; d0 = n_done;
    pulse_start(m, c0);
    wait_done(d0 + 1);
    check("basic_count", 64'(n_xfer - x0), 64'(FRAME));
    check("basic_no_bubbles", 64'(done_cyc - c0), 64'(FRAME + 1));
    check("basic_sb_empty", 64'(sb.size()), 64'd0);
    idle_cycles(3, d0 + 1);

    // Backpressure 1,0,0,1.
    push_frame(m);
    x0 = n_xfer; d0 = n_done;
    bp_mode = 1'b1;
    pulse_start(m, c0);
    wait_done(d0 + 1);
    bp_mode = 1'b0;
    check("bp_count", 64'(n_xfer - x0), 64'(FRAME));
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    idle_cycles(3, d0 + 1);

    // Start and new mat_in during the frame are ignored.
    push_frame(m);
    x0 = n_xfer; d0 = n_done;
    pulse_start(m, c0);
    wait_xfer(x0 + 7);
    mat_in = '1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0 + 1);
    check("ignore_count", 64'(n_xfer - x0), 64'(FRAME));
    idle_cycles(5, d0 + 1);

    // Reset mid-frame after word 12, then a fresh frame from (0,0).
    push_frame(m);
    x0 = n_xfer; d0 = n_done;
    pulse_start(m, c0);
    wait_xfer(x0 + 12);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_if.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outs", {out_if.out_data, out_if.out_row, out_if.out_col, out_if.out_last, done}, '0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(3, d0);
    push_frame(m);
    x0 = n_xfer;
    pulse_start(m, c0);
    check("restart_row", out_if.out_row, '0);
    check("restart_col", out_if.out_col, '0);
    wait_done(d0 + 1);
    check("restart_count", 64'(n_xfer - x0), 64'(FRAME));

`ifdef MATRIX_SER_ROW_SUM_EN
    // Row sums: row 0 = 1..5 (sum 15), row 1 = all ones (sum FFFFFFFB).
    m = pattern_mat();
    for (int c = 0; c < N; c++) begin
      m[elem_lsb(0, c) +: W] = W'(c + 1);
      m[elem_lsb(1, c) +: W] = '1;
    end
    push_frame(m);
    check("sum0_model", sb[N].data, 32'd15);
    check("sum1_model", sb[2*N+1].data, 32'hFFFFFFFB);
    x0 = n_xfer; d0 = n_done;
    bp_mode = 1'b1;
    pulse_start(m, c0);
    wait_done(d0 + 1);
    bp_mode = 1'b0;
    check("sum_count", 64'(n_xfer - x0), 64'(N * (N + 1)));
`endif

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Consumer end of the 5x5 inverse engine's parallel result outputs (identity11..identity55).
- Snapshots all N*N words on a start pulse.
- Streams them out one word per accepted transfer, in row-major order, over a valid/ready interface.
- Lets a narrow downstream (UART bridge, memory writer, testbench checker) read the inverse without 25 parallel 32-bit buses.

Parameters:
- N, 5, matrix dimension (rows = cols).
- W, 32, element width in bits.
- IDX_W, 3, width of row/col index outputs; must satisfy 2**IDX_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to capture mat_in and begin streaming.
- mat_in  input  N*N*W  flattened matrix; element (r,c) occupies bits [(r*N+c)*W +: W]; identity11 maps to r=0,c=0.
- out_data  output  W  current element.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts the current word.
- out_row  output  IDX_W  row index of out_data.
- out_col  output  IDX_W  column index of out_data.
- out_last  output  1  high with the final word of the frame.
- busy  output  1  high from capture until the final transfer completes.
- done  output  1  one-cycle pulse the cycle after the final transfer.

Behaviour:
- Reset (reset=0, async): state=IDLE; buffer cleared to 0; out_data=0, out_valid=0, out_row=0, out_col=0, out_last=0, busy=0, done=0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 at a rising edge copies mat_in into the internal N*N*W buffer.
  - Row/col counters set to 0; next state STREAM.
  - start=0: remain in IDLE.
- Latency: out_valid=1 in the cycle after start is sampled; first word is element (0,0).
- STREAM:
  - A transfer occurs at an edge where out_valid=1 and out_ready=1.
  - On transfer: col increments; when col=N-1 it wraps to 0 and row increments.
  - On the transfer of (N-1,N-1): next state DONE, out_valid=0.
- Hold rule: while out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last stay unchanged.
- out_valid never deasserts mid-frame except in the optional feature gap case below (it does not).
- out_last = 1 exactly when row=N-1 and col=N-1 (and out_valid=1).
- DONE: done=1 for exactly one cycle, busy=0 in that cycle; next state IDLE.
- busy = 1 in STREAM, 0 in IDLE and DONE.
- start while in STREAM or DONE is ignored; the buffer is not overwritten and no frame is queued.
- Changes on mat_in after capture have no effect on the frame in flight.
- out_ready held 1 continuously: N*N words on N*N consecutive cycles, no bubbles.
- Reset mid-frame: immediate abort, all outputs to reset values; no done pulse.
- out_data is driven from the registered buffer via the index mux; no combinational path from mat_in to out_data.

Optional Feature:
- Macro: MATRIX_SER_ROW_SUM_EN.
- With the macro: after each row's N-th word, one extra word is emitted.
  - Extra word value: mod-2^W wrapping sum of that row's N elements.
  - out_col = N on that word; out_row = current row.
  - A frame is N*(N+1) words.
  - out_last is set on the row N-1 sum word, not on element (N-1,N-1).
  - The sum word obeys the same hold rule.
- Without the macro: exactly N*N words; out_col never exceeds N-1.
- IDX_W must then satisfy 2**IDX_W > N.

Decomposition:
- Shared package matrix_pkg holds:
  - constants MAT_N=5, MAT_W=32;
  - state enum type ser_state_t {IDLE, STREAM, DONE};
  - function elem_lsb(r,c) returning (r*MAT_N+c)*MAT_W.
- One sub-module, matrix_index_counter: row/col counter with advance and clear inputs.
  - Its wrap limit is N, or N+1 under MATRIX_SER_ROW_SUM_EN.
  - Outputs row, col and a last flag.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> all outputs 0, busy=0; no activity for 10 cycles with start=0.
- Basic frame: element (r,c)=32'h100*r+c, start pulse, out_ready=1 -> out_valid rises the next cycle.
  - Words 0x000,0x001..0x004,0x100..0x404 arrive on 25 consecutive cycles.
  - out_last on 0x404; done pulses once, 1 cycle later; busy falls with done.
- Backpressure: same matrix, out_ready toggles 1,0,0,1 repeating -> exactly 25 transfers, order unchanged, out_data stable during every ready=0 cycle.
- Start ignored when busy: second start and mat_in changed to all 32'hFFFFFFFF during word 7 -> remaining words still match the first snapshot; only one done pulse.
- Reset mid-frame: reset=0 after word 12 -> out_valid=0 and busy=0 asynchronously, no done.
  - A new start then streams from (0,0).
- Row sum (macro on): row 0 = 1,2,3,4,5 -> sixth word 15 with out_col=5.
  - Row of 32'hFFFFFFFF x5 -> sum 32'hFFFFFFFB.
  - 30 words total; out_last on the final sum word.
